mem_wr_demux: RTL and testbench

- Parametrised, registered write-strobe demultiplexer for the memory array.
- Accepts write beats over a valid/ready handshake.
- Drives exactly one word-line write enable per accepted beat, one-hot over DEPTH words, with the write data registered alongside it.
- Supports single writes and auto-incrementing bursts with address wrap-around, then reports completion with a one-cycle done pulse.

---
 rtl/mem_wr_demux.sv | 62 ++++++
 tb/tb_mem_wr_demux.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_wr_demux.sv
// mem_wr_demux: registered one-hot write-strobe demux with auto-incrementing wrapping bursts
module mem_wr_demux #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  localparam int DEPTH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [ADDR_W-1:0] in_len,
  input  logic [DATA_W-1:0] in_data,
  output logic [DEPTH-1:0]  we,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] ptr, rem, wa;
  logic acc;
  assign in_ready = state != DONE;
  assign acc = in_valid && in_ready;
  // first beat writes at the supplied address, later beats at the running pointer
  always_comb wa = state == IDLE ? in_addr : ptr;
  // transfer sequencing with registered strobe, data, busy and done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      rem   <= '0;
      we    <= '0;
      wdata <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      we    <= acc ? DEPTH'(1) << wa : '0;
      wdata <= acc ? in_data : '0;
      done  <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          ptr   <= in_addr + 1'b1;
          rem   <= in_len;
          state <= in_len == '0 ? DONE : BURST;
          busy  <= in_len != '0;
          done  <= in_len == '0;
        end
        BURST: if (acc) begin
          ptr <= ptr + 1'b1;
          rem <= rem - 1'b1;
          if (rem == ADDR_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_wr_demux.sv
// tb_mem_wr_demux: randomized self-checking bench for mem_wr_demux with a transfer-level model
module tb_mem_wr_demux;
  localparam int AW = 3, DW = 8, D = 8;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic in_valid = 0;
  logic [AW-1:0] in_addr = 0, in_len = 0;
  logic [DW-1:0] in_data = 0;
  logic in_ready, busy, done;
  logic [D-1:0] we;
  logic [DW-1:0] wdata;
  logic v2 = 0;
  logic [3:0] a2 = 0, l2 = 0;
  logic [15:0] d2 = 0;
  logic r2, b2, dn2;
  logic [15:0] we2, wd2;
  int checks = 0, errors = 0;

  mem_wr_demux dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_len(in_len), .in_data(in_data), .we(we), .wdata(wdata),
    .busy(busy), .done(done));

  mem_wr_demux #(.ADDR_W(4), .DATA_W(16)) dut2 (.clk(clk), .rst(rst), .in_valid(v2),
    .in_ready(r2), .in_addr(a2), .in_len(l2), .in_data(d2), .we(we2), .wdata(wd2),
    .busy(b2), .done(dn2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int a, input int l, input int abort_at);
    logic [DW-1:0] d;
    logic [D-1:0] e;
    for (int i = 0; i <= l; i++) begin
      if (i > 0 && $urandom_range(0, 2) == 0) begin
        in_valid = 0;
        step();
        chk("gap_we", 32'(we), 0);
        chk("gap_busy", 32'(busy), 1);
        chk("gap_done", 32'(done), 0);
      end
      if (i == abort_at) begin
        in_valid = 1;
        #1 rst = 1;
        #1;
        chk("rst_we", 32'(we), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(in_ready), 1);
        #1 rst = 0;
        in_valid = 0;
        return;
      end
      d = DW'($urandom);
      in_valid = 1;
      in_addr = i == 0 ? AW'(a) : AW'($urandom);
      in_len = i == 0 ? AW'(l) : AW'($urandom);
      in_data = d;
      chk("ready_pre", 32'(in_ready), 1);
      step();
      e = '0;
      e[(a + i) % D] = 1'b1;
      chk("we", 32'(we), 32'(e));
      chk("wdata", 32'(wdata), 32'(d));
      chk("done", 32'(done), 32'(i == l));
      chk("busy", 32'(busy), 32'(i < l));
      chk("ready", 32'(in_ready), 32'(i != l));
    end
    in_valid = 0;
    step();
    chk("idle_we", 32'(we), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(in_ready), 1);
  endtask

  initial begin
    in_valid = 1;
    #2;
    chk("init_we", 32'(we), 0);
    chk("init_wdata", 32'(wdata), 0);
    chk("init_busy", 32'(busy), 0);
    chk("init_done", 32'(done), 0);
    chk("init_ready", 32'(in_ready), 1);
    #1 rst = 0;
    in_valid = 0;
    step();
    chk("post_rst_we", 32'(we), 0);
    chk("post_rst_ready", 32'(in_ready), 1);
    xfer(5, 0, -1);
    xfer(6, 3, -1);
    xfer(0, 2, -1);
    xfer(2, 7, 3);
    xfer(4, 0, -1);
    xfer(7, 7, -1);
    in_valid = 1; in_addr = 3; in_len = 0; in_data = 8'h3c;
    step();
    chk("hold_we1", 32'(we), 32'h08);
    chk("hold_done1", 32'(done), 1);
    chk("hold_ready1", 32'(in_ready), 0);
    in_addr = 7; in_data = 8'h7e;
    step();
    chk("hold_we_gap", 32'(we), 0);
    chk("hold_ready2", 32'(in_ready), 1);
    chk("hold_done2", 32'(done), 0);
    step();
    chk("hold_we2", 32'(we), 32'h80);
    chk("hold_wdata2", 32'(wdata), 32'h7e);
    chk("hold_done3", 32'(done), 1);
    in_valid = 0;
    step();
    for (int k = 0; k < 25; k++)
      xfer($urandom_range(0, D - 1), $urandom_range(0, D - 1), -1);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] e2, dd;
      dd = 16'($urandom);
      v2 = 1;
      a2 = i == 0 ? 4'd9 : 4'($urandom);
      l2 = i == 0 ? 4'd15 : 4'($urandom);
      d2 = dd;
      step();
      e2 = '0;
      e2[(9 + i) % 16] = 1'b1;
      chk("p_we", 32'(we2), 32'(e2));
      chk("p_wdata", 32'(wd2), 32'(dd));
      chk("p_done", 32'(dn2), 32'(i == 15));
      chk("p_busy", 32'(b2), 32'(i < 15));
    end
    v2 = 0;
    step();
    chk("p_idle_we", 32'(we2), 0);
    chk("p_idle_ready", 32'(r2), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
